// File: rtl/adder_slice_seq.sv
`default_nettype none
// ==========================================================================
// adder_slice_seq : 12-bit add, 4 cycles through one shared 3-bit slice
// Option macro ADDER_SLICE_SEQ_SUB_EN adds a-b | Rev 1.0
// ==========================================================================
module adder_slice_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] a,
    input  logic [11:0] b,
    input  logic        cin,
    input  logic        sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] sum,
    output logic        cout
);
    localparam logic [1:0] c_LAST_STEP = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [11:0] r_a;
    logic [11:0] r_b;
    logic [11:0] r_sum;
    logic        r_carry;
    logic        r_cout;
    logic [1:0]  r_k;

    logic [11:0] w_b_in;
    logic        w_carry_in;
    logic [2:0]  w_slice_a;
    logic [2:0]  w_slice_b;
    logic [3:0]  w_slice;

`ifdef ADDER_SLICE_SEQ_SUB_EN
    // Subtract as a + ~b + 1; carry-out of 1 then means no borrow.
    assign w_b_in     = sub ? ~b : b;
    assign w_carry_in = sub ? 1'b1 : cin;
`else
    logic w_unused_sub;
    assign w_unused_sub = sub;
    assign w_b_in       = b;
    assign w_carry_in   = cin;
`endif

    assign w_slice_a = r_a[3*r_k +: 3];
    assign w_slice_b = r_b[3*r_k +: 3];
    assign w_slice   = {1'b0, w_slice_a} + {1'b0, w_slice_b} + {3'b000, r_carry};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                if (r_k == c_LAST_STEP) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Step counter wraps 3->0 exactly on the RUN->DONE transition.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= 12'h000;
            r_b     <= 12'h000;
            r_sum   <= 12'h000;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_k     <= 2'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= w_b_in;
                        r_carry <= w_carry_in;
                        r_k     <= 2'd0;
                    end
                end
                RUN: begin
                    r_sum[3*r_k +: 3] <= w_slice[2:0];
                    r_carry           <= w_slice[3];
                    r_k               <= r_k + 2'd1;
                    if (r_k == c_LAST_STEP) begin
                        r_cout <= w_slice[3];
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule
`default_nettype wire
